// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send,
// then shifts one command byte out on device-generated clock edges.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 100,
  parameter int TIMEOUT_CYCLES = 30000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_low,
  output logic       ps2_data_low,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       done,
  output logic       err
);

  localparam int CMAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ?
                        TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CW = $clog2(CMAX) + 1;
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_DATA,
    S_ACK,
    S_WAIT
  } state_t;

  state_t        r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [3:0]    r_bit, w_bit_nx;
  logic [8:0]    r_shift, w_shift_nx;
  logic          r_dlow, w_dlow_nx;
  logic          r_done, w_done_nx;
  logic          r_err, w_err_nx;

  logic r_clk_s1, r_clk_s2, r_clk_prev;
  logic r_dat_s1, r_dat_s2;
  logic w_fall;
  logic w_busy;
  logic w_timeout;

  // Sync flops idle high so reset never fakes a falling edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1   <= ps2_clk;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= ps2_data;
      r_dat_s2   <= r_dat_s1;
    end
  end

  assign w_fall = r_clk_prev & ~r_clk_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_dlow  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_bit   <= w_bit_nx;
      r_shift <= w_shift_nx;
      r_dlow  <= w_dlow_nx;
      r_done  <= w_done_nx;
      r_err   <= w_err_nx;
    end
  end

  assign w_busy = (r_state == S_REQ) || (r_state == S_DATA) ||
                  (r_state == S_ACK) || (r_state == S_WAIT);
  assign w_timeout = w_busy && (r_cnt == TO_LAST);

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_bit_nx   = r_bit;
    w_shift_nx = r_shift;
    w_dlow_nx  = r_dlow;
    w_done_nx  = 1'b0;
    w_err_nx   = 1'b0;
    if (w_busy) w_cnt_nx = r_cnt + CW'(1);
    if (w_timeout) begin
      w_state_nx = S_IDLE;
      w_cnt_nx   = '0;
      w_dlow_nx  = 1'b0;
      w_err_nx   = 1'b1;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (tx_valid) begin
            w_shift_nx = {~^tx_data, tx_data};
            w_cnt_nx   = '0;
            w_state_nx = S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (r_cnt == INH_LAST) begin
            w_cnt_nx   = '0;
            w_bit_nx   = '0;
            w_state_nx = S_REQ;
          end else begin
            w_cnt_nx = r_cnt + CW'(1);
          end
        end
        S_REQ: begin
          if (w_fall) begin
            w_dlow_nx  = ~r_shift[0];
            w_shift_nx = {1'b0, r_shift[8:1]};
            w_bit_nx   = 4'd1;
            w_state_nx = S_DATA;
          end
        end
        S_DATA: begin
          // r_bit counts edges seen; edge 10 is the stop bit
          if (w_fall) begin
            if (r_bit == 4'd9) begin
              w_dlow_nx  = 1'b0;
              w_state_nx = S_ACK;
            end else begin
              w_dlow_nx  = ~r_shift[0];
              w_shift_nx = {1'b0, r_shift[8:1]};
              w_bit_nx   = r_bit + 4'd1;
            end
          end
        end
        S_ACK: begin
          if (w_fall) begin
            if (r_dat_s2) begin
              w_err_nx   = 1'b1;
              w_cnt_nx   = '0;
              w_state_nx = S_IDLE;
            end else begin
              w_state_nx = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (r_clk_s2 && r_dat_s2) begin
            w_done_nx  = 1'b1;
            w_cnt_nx   = '0;
            w_state_nx = S_IDLE;
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  assign ps2_clk_low  = (r_state == S_INHIBIT);
  assign ps2_data_low = ((r_state == S_INHIBIT) && (r_cnt == INH_LAST)) ||
                        (r_state == S_REQ) ||
                        ((r_state == S_DATA) && r_dlow);
  assign tx_ready     = (r_state == S_IDLE);
  assign done         = r_done;
  assign err          = r_err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain keyboard model clocks the frame
// out and compares it against a frame built from the byte's bit count.
module tb_ps2_host_tx;

  localparam int INH = 100;
  localparam int TO  = 15000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       ps2_clk_low, ps2_data_low, tx_ready, done, err;
  wire        pad_clk  = dev_clk & ~ps2_clk_low;
  wire        pad_data = dev_data & ~ps2_data_low;

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .ps2_clk      (pad_clk),
    .ps2_data     (pad_data),
    .ps2_clk_low  (ps2_clk_low),
    .ps2_data_low (ps2_data_low),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .done         (done),
    .err          (err)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int cyc = 0, n_done = 0, n_err = 0, n_both = 0;
  int low_cycles = 0, n_acc = 0;
  int req_cyc = 0, err_cyc = 0, done_cyc = 0, inh_cyc = 0;
  logic [2:0] err_snap = '0;
  logic prev_clk_low = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (done) begin n_done++; done_cyc = cyc; end
    if (err) begin
      n_err++;
      err_cyc  = cyc;
      err_snap = {ps2_clk_low, ps2_data_low, tx_ready};
    end
    if (done && err) n_both++;
    if (ps2_clk_low) low_cycles++;
    if (prev_clk_low && !ps2_clk_low) req_cyc = cyc;
    if (!prev_clk_low && ps2_clk_low) inh_cyc = cyc;
    prev_clk_low = ps2_clk_low;
  end

  always @(posedge clk)
    if (!rst && tx_valid && tx_ready) n_acc++;

  // Frame as the device should see it: start, LSB-first data, odd parity, stop
  function automatic logic [10:0] ref_frame(input logic [7:0] d);
    int ones;
    ones = $countones(d);
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d, 1'b0};
  endfunction

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic dev_xfer(input int half, input bit ack, input int abort_after,
                          output logic [10:0] frame, output logic late_low);
    int n;
    frame = '1;
    late_low = 1'b0;
    n = 0;
    while (!ps2_clk_low && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) begin check("dev_inhibit_seen", 0, 1); return; end
    n = 0;
    while (ps2_clk_low && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) begin check("dev_request_seen", 0, 1); return; end
    @(negedge clk);
    frame[0] = pad_data;
    repeat (half) @(negedge clk);
    for (int i = 1; i <= 10; i++) begin
      dev_clk = 1'b0;
      repeat (half) @(negedge clk);
      dev_clk = 1'b1;
      frame[i] = pad_data;
      if (i == abort_after) return;
      if (i < 10) repeat (half) @(negedge clk);
    end
    repeat (half / 2) begin
      @(negedge clk);
      if (ps2_data_low) late_low = 1'b1;
    end
    if (ack) dev_data = 1'b0;
    repeat (half - half / 2) begin
      @(negedge clk);
      if (ps2_data_low) late_low = 1'b1;
    end
    dev_clk = 1'b0;
    repeat (half) begin
      @(negedge clk);
      if (ps2_data_low) late_low = 1'b1;
    end
    dev_clk = 1'b1;
    repeat (4) @(negedge clk);
    dev_data = 1'b1;
  endtask

  task automatic wait_end(input int d0, input int e0);
    int n;
    n = 0;
    while (n_done == d0 && n_err == e0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic run_xfer(input logic [7:0] d, input int half, input bit ack,
                          input string tag);
    logic [10:0] fr;
    logic        late;
    int d0, e0, l0;
    d0 = n_done;
    e0 = n_err;
    l0 = low_cycles;
    send(d);
    dev_xfer(half, ack, 0, fr, late);
    wait_end(d0, e0);
    check({tag, "_frame"}, 32'(fr), 32'(ref_frame(d)));
    check({tag, "_inhibit_len"}, low_cycles - l0, INH);
    check({tag, "_done"}, n_done - d0, ack ? 1 : 0);
    check({tag, "_err"}, n_err - e0, ack ? 0 : 1);
    check({tag, "_late_data_low"}, 32'(late), 0);
    check({tag, "_ready"}, 32'(tx_ready), 1);
  endtask

  logic [10:0] fr;
  logic        late;
  logic [7:0]  a, b;
  int d0, e0, acc0, n;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_clk_low", 32'(ps2_clk_low), 0);
    check("rst_data_low", 32'(ps2_data_low), 0);
    check("rst_ready", 32'(tx_ready), 1);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      dev_clk = ~dev_clk;
      dev_data = $urandom_range(0, 1);
      repeat (20) @(negedge clk);
    end
    dev_clk = 1'b1;
    dev_data = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_pads_ready", 32'(tx_ready), 1);
    check("idle_pads_clk_low", 32'(ps2_clk_low), 0);
    check("idle_pads_events", n_done + n_err, 0);

    run_xfer(8'hED, 500, 1'b1, "ed");
    run_xfer(8'h07, 200, 1'b1, "x07");
    for (int i = 0; i < 3; i++)
      run_xfer(8'($urandom), 200, 1'b1, "rnd");

    d0 = n_done;
    e0 = n_err;
    send(8'($urandom));
    n = 0;
    while (n_err == e0 && n < TO + 1000) begin @(negedge clk); n++; end
    check("to_err", n_err - e0, 1);
    check("to_latency", err_cyc - req_cyc, TO);
    check("to_lines_ready", 32'(err_snap), 32'b001);
    check("to_no_done", n_done - d0, 0);
    repeat (10) @(negedge clk);

    run_xfer(8'($urandom), 200, 1'b0, "noack");

    d0 = n_done;
    e0 = n_err;
    send(8'($urandom));
    dev_xfer(200, 1'b1, 4, fr, late);
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_clk_low", 32'(ps2_clk_low), 0);
    check("mid_rst_data_low", 32'(ps2_data_low), 0);
    check("mid_rst_ready", 32'(tx_ready), 1);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("mid_rst_events", (n_done - d0) + (n_err - e0), 0);
    run_xfer(8'hFF, 200, 1'b1, "ff");

    a = 8'($urandom);
    b = 8'($urandom);
    acc0 = n_acc;
    d0 = n_done;
    e0 = n_err;
    @(negedge clk);
    tx_data = a;
    tx_valid = 1'b1;
    n = 0;
    while (!ps2_clk_low && n < 20) begin @(negedge clk); n++; end
    tx_data = b;
    dev_xfer(200, 1'b1, 0, fr, late);
    n = 0;
    while (n_done == d0 && n_err == e0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    tx_valid = 1'b0;
    check("held_first_frame", 32'(fr), 32'(ref_frame(a)));
    check("held_reaccept_gap", inh_cyc - done_cyc, 1);
    check("held_first_accepts", n_acc - acc0, 2);
    d0 = n_done;
    e0 = n_err;
    dev_xfer(200, 1'b1, 0, fr, late);
    wait_end(d0, e0);
    check("held_second_frame", 32'(fr), 32'(ref_frame(b)));
    check("held_second_done", n_done - d0, 1);
    repeat (50) @(negedge clk);
    check("held_total_accepts", n_acc - acc0, 2);
    check("never_done_and_err", n_both, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. It sends one command byte (e.g. 0xED "set LEDs", 0xFF "reset") from the calculator core to the attached keyboard.
- Counterpart of the existing PS/2 receive path: the keyboard still generates the clock, and this block requests the transfer and shifts out the bits.
- Drives the open-drain ps2_clk/ps2_data pads via pull-low enables. It owns the bus only while busy; the receiver must ignore the lines while tx_ready=0.

Parameters:
- INHIBIT_CYCLES, 100: clk cycles ps2_clk is held low before the request (100 us at 1 MHz).
- TIMEOUT_CYCLES, 30000: max clk cycles from release of ps2_clk to transfer completion.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- ps2_clk  in  1  PS/2 clock line as read at pad (asynchronous)
- ps2_data  in  1  PS/2 data line as read at pad (asynchronous)
- ps2_clk_low  out  1  1 = pull ps2_clk low, 0 = release
- ps2_data_low  out  1  1 = pull ps2_data low, 0 = release
- tx_data  in  8  command byte
- tx_valid  in  1  request; accepted when tx_valid & tx_ready
- tx_ready  out  1  1 only in IDLE
- done  out  1  1-cycle pulse: byte sent and device ACKed
- err  out  1  1-cycle pulse: timeout or missing ACK

Behaviour:
- Reset (synchronous, active-high) takes effect on the next clk edge, including mid-transfer:
  - state=IDLE; ps2_clk_low=0; ps2_data_low=0; tx_ready=1; done=0; err=0; counters=0.
- Input sync and edge detect:
  - ps2_clk and ps2_data each pass through a 2-flop synchronizer.
  - A falling edge is sync_clk_prev=1 and sync_clk=0 (a 1-cycle event, 3 clk after the pad edge).
- Accept: in IDLE with tx_valid=1, latch shift = {odd_parity(tx_data), tx_data}, where parity = ~^tx_data. Next state is INHIBIT and tx_ready drops next cycle.
- INHIBIT: ps2_clk_low=1 for exactly INHIBIT_CYCLES cycles. On the last cycle assert ps2_data_low=1 (start bit). Then go to REQ.
- REQ: ps2_clk_low=0, ps2_data_low=1. The timeout counter starts at 0 and bit_cnt=0.
- Falling edges of ps2_clk, counted from the first after REQ entry:
  - Edges 1..8: ps2_data_low = ~tx_data[bit_cnt], LSB first.
  - Edge 9: ps2_data_low = ~parity.
  - Edge 10: ps2_data_low=0 (stop bit, line released). State goes to ACK.
  - Edge 11 (in ACK): sample sync ps2_data.
    - 0 → go to WAIT_IDLE.
    - 1 → pulse err, go to IDLE.
  - Note: the start bit is already on the line in REQ; each data bit changes while ps2_clk is low, so the device samples it on the rising edge.
- WAIT_IDLE: wait until sync ps2_clk=1 and sync ps2_data=1 in the same cycle. Then pulse done and go to IDLE (tx_ready=1 in the same cycle as done).
- Timeout:
  - The counter runs in REQ, DATA, ACK and WAIT_IDLE.
  - On reaching TIMEOUT_CYCLES-1: release both lines next cycle, pulse err, go to IDLE.
  - Timeout takes priority over a same-cycle edge.
- done and err are never asserted together.
- tx_valid is ignored while tx_ready=0. tx_data may change after acceptance.
- In IDLE both lines are released. Pad activity in IDLE has no effect.

Test Plan:
- tx_data=0xED, device model with 1000-cycle ps2_clk period that ACKs:
  - ps2_clk_low high for exactly 100 cycles.
  - Device samples start 0, data 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - done pulses once, err stays 0.
- tx_data=0x07: parity 0 sampled at bit 9; done pulses.
- Device never clocks after request: err pulses at TIMEOUT_CYCLES after REQ entry; both lines released; tx_ready=1.
- Device leaves data high at edge 11 (no ACK): err pulse, no done; ps2_data_low=0 from edge 10 on.
- rst asserted during bit 4: next cycle both lines released, tx_ready=1; a following 0xFF transfer completes normally with parity 1.
- tx_valid held high through a transfer: exactly one byte accepted. A second byte is accepted only in the cycle after done.
